// File: rtl/dprintf_byte_emitter.sv
// dprintf formatter: walks a 32-byte payload and emits ASCII characters one per cycle.
// Define DPRINTF_BYTE_EMITTER_HEX_EN to enable 0x8N hex-field expansion.
module dprintf_byte_emitter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req__valid,
    input  logic [15:0] req__address,
    input  logic [63:0] req__data_0,
    input  logic [63:0] req__data_1,
    input  logic [63:0] req__data_2,
    input  logic [63:0] req__data_3,
    output logic        ack,
    output logic        byte__valid,
    output logic [15:0] byte__address,
    output logic [7:0]  byte__data,
    input  logic        byte__ready
);

`ifdef DPRINTF_BYTE_EMITTER_HEX_EN
    typedef enum logic [1:0] {IDLE, SCAN, HEX} state_t;
`else
    typedef enum logic [1:0] {IDLE, SCAN} state_t;
`endif

    state_t       state, state_n;
    logic [5:0]   ptr, ptr_n;
    logic [255:0] payload;
    logic [15:0]  next_addr;
    logic         cap, emit, free;
    logic [7:0]   emit_data;
    logic [7:0]   bidx;
    logic [7:0]   cur_byte;
    logic [6:0]   ptr_p2;

`ifdef DPRINTF_BYTE_EMITTER_HEX_EN
    logic [3:0]   cnt, cnt_n;
    logic [7:0]   nidx;
    logic [3:0]   cur_nib;
    logic [6:0]   ptr_p1, ptr_rnd;

    assign nidx    = 8'd255 - {ptr, 2'b00};
    assign cur_nib = payload[nidx -: 4];
    assign ptr_p1  = {1'b0, ptr} + 7'd1;
    assign ptr_rnd = ptr_p1 + {6'b0, ptr_p1[0]};
`endif

    assign free     = !byte__valid || byte__ready;
    assign bidx     = 8'd255 - {ptr[5:1], 3'b000};
    assign cur_byte = payload[bidx -: 8];
    assign ptr_p2   = {1'b0, ptr} + 7'd2;

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        cap       = 1'b0;
        emit      = 1'b0;
        emit_data = 8'h00;
`ifdef DPRINTF_BYTE_EMITTER_HEX_EN
        cnt_n     = cnt;
`endif
        case (state)
            IDLE: begin
                if (req__valid) begin
                    cap     = 1'b1;
                    ptr_n   = 6'd0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (free) begin
                    ptr_n = ptr_p2[5:0];
                    if (ptr_p2[6])
                        state_n = IDLE;
                    unique case (1'b1)
                        (cur_byte == 8'hFF): begin
                            state_n = IDLE;
                        end
                        (cur_byte >= 8'h20 && cur_byte <= 8'h7E): begin
                            emit      = 1'b1;
                            emit_data = cur_byte;
                        end
`ifdef DPRINTF_BYTE_EMITTER_HEX_EN
                        (cur_byte[7:4] == 4'h8): begin
                            cnt_n = cur_byte[3:0];
                            if (!ptr_p2[6])
                                state_n = HEX;
                        end
`endif
                        default: ;
                    endcase
                end
            end
`ifdef DPRINTF_BYTE_EMITTER_HEX_EN
            HEX: begin
                if (free) begin
                    emit      = 1'b1;
                    emit_data = (cur_nib < 4'd10) ? 8'h30 + {4'h0, cur_nib}
                                                  : 8'h37 + {4'h0, cur_nib};
                    if (cnt == 4'd0) begin
                        // odd pointer rounds up to the next byte boundary
                        ptr_n   = ptr_rnd[5:0];
                        state_n = ptr_rnd[6] ? IDLE : SCAN;
                    end else begin
                        cnt_n = cnt - 4'd1;
                        ptr_n = ptr_p1[5:0];
                        if (ptr_p1[6])
                            state_n = IDLE;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            ptr           <= 6'd0;
            payload       <= '0;
            next_addr     <= 16'h0000;
            ack           <= 1'b0;
            byte__valid   <= 1'b0;
            byte__data    <= 8'h00;
            byte__address <= 16'h0000;
`ifdef DPRINTF_BYTE_EMITTER_HEX_EN
            cnt           <= 4'd0;
`endif
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            ack   <= cap;
`ifdef DPRINTF_BYTE_EMITTER_HEX_EN
            cnt   <= cnt_n;
`endif
            if (cap) begin
                payload   <= {req__data_0, req__data_1, req__data_2, req__data_3};
                next_addr <= req__address;
            end
            if (emit) begin
                byte__valid   <= 1'b1;
                byte__data    <= emit_data;
                byte__address <= next_addr;
                next_addr     <= next_addr + 16'd1;
            end else if (byte__ready) begin
                byte__valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dprintf_byte_emitter.sv
// Directed vector bench for dprintf_byte_emitter (default and HEX_EN builds).
module tb_dprintf_byte_emitter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req__valid;
    logic [15:0] req__address;
    logic [63:0] req__data_0, req__data_1, req__data_2, req__data_3;
    logic        ack;
    logic        byte__valid;
    logic [15:0] byte__address;
    logic [7:0]  byte__data;
    logic        byte__ready;

    int tests = 0;
    int fails = 0;
    int stall_left = 0;
    logic [7:0]  rx_d[$];
    logic [15:0] rx_a[$];
    logic        held = 1'b0;
    logic [24:0] held_v;

    typedef struct {
        logic [15:0] addr;
        logic [63:0] d0, d1, d2, d3;
        int          n;
        logic [63:0] exp;
    } vec_t;
    vec_t vt[5];

    dprintf_byte_emitter dut (
        .clk(clk), .reset_n(reset_n),
        .req__valid(req__valid), .req__address(req__address),
        .req__data_0(req__data_0), .req__data_1(req__data_1),
        .req__data_2(req__data_2), .req__data_3(req__data_3),
        .ack(ack), .byte__valid(byte__valid),
        .byte__address(byte__address), .byte__data(byte__data),
        .byte__ready(byte__ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // drive ready for the coming edge, record accepted bytes, check holds
    always @(negedge clk) begin
        if (!reset_n) begin
            byte__ready = 1'b1;
            held = 1'b0;
        end else begin
            if (held)
                chk("hold_stable", {7'b0, byte__valid, byte__data, byte__address},
                    {7'b0, held_v});
            if (stall_left > 0 && byte__valid && rx_d.size() == 1) begin
                byte__ready = 1'b0;
                stall_left--;
            end else begin
                byte__ready = 1'b1;
            end
            held   = byte__valid && !byte__ready;
            held_v = {byte__valid, byte__data, byte__address};
            if (byte__valid && byte__ready) begin
                rx_d.push_back(byte__data);
                rx_a.push_back(byte__address);
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [63:0] d0, d1, d2, d3);
        logic got;
        got = 1'b0;
        @(negedge clk);
        req__address = a;
        req__data_0 = d0; req__data_1 = d1;
        req__data_2 = d2; req__data_3 = d3;
        req__valid = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = ack;
        end
        chk("ack_seen", {31'b0, got}, 32'd1);
        req__valid = 1'b0;
        @(negedge clk);
        chk("ack_pulse_one_cycle", {31'b0, ack}, 32'd0);
    endtask

    task automatic clear_rx();
        rx_d.delete();
        rx_a.delete();
    endtask

    initial begin
        logic [63:0] e;
        logic [15:0] ea;

        vt[0] = '{16'h0050, 64'h4142FF00_00000000, 64'h0, 64'h0, 64'h0,
                  2, 64'h4142_0000_0000_0000};
        vt[3] = '{16'h2000, 64'h207E7F1F_31FF0000, 64'h0, 64'h0, 64'h0,
                  3, 64'h207E31_0000000000};
`ifdef DPRINTF_BYTE_EMITTER_HEX_EN
        vt[1] = '{16'd100, 64'h87DEADBE_EFFF0000, 64'h0, 64'h0, 64'h0,
                  8, 64'h44454144_42454546};
        vt[2] = '{16'h1234, 64'h82ABCD41_FF000000, 64'h0, 64'h0, 64'h0,
                  4, 64'h41424341_00000000};
        vt[4] = '{16'hFFFF, 64'h0, 64'h0, 64'h0, 64'h00000000_0000835A,
                  2, 64'h3541_0000_0000_0000};
`else
        vt[1] = '{16'd100, 64'h87DEADBE_EFFF0000, 64'h0, 64'h0, 64'h0,
                  0, 64'h0};
        vt[2] = '{16'h1234, 64'h82ABCD41_FF000000, 64'h0, 64'h0, 64'h0,
                  1, 64'h41000000_00000000};
        vt[4] = '{16'hFFFF, 64'h0, 64'h0, 64'h0, 64'h00000000_0000835A,
                  1, 64'h5A00_0000_0000_0000};
`endif

        reset_n = 1'b0;
        req__valid = 1'b0;
        req__address = 16'h0;
        req__data_0 = 64'h0; req__data_1 = 64'h0;
        req__data_2 = 64'h0; req__data_3 = 64'h0;
        byte__ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_valid", {31'b0, byte__valid}, 32'd0);
        chk("rst_addr", {16'b0, byte__address}, 32'd0);
        chk("rst_data", {24'b0, byte__data}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            clear_rx();
            send(vt[i].addr, vt[i].d0, vt[i].d1, vt[i].d2, vt[i].d3);
            repeat (50) @(negedge clk);
            chk($sformatf("v%0d_count", i), rx_d.size(), vt[i].n);
            e = vt[i].exp;
            for (int j = 0; j < vt[i].n && j < rx_d.size(); j++) begin
                ea = vt[i].addr + j[15:0];
                chk($sformatf("v%0d_byte%0d", i, j), {24'b0, rx_d[j]},
                    {24'b0, e[63-8*j -: 8]});
                chk($sformatf("v%0d_addr%0d", i, j), {16'b0, rx_a[j]}, {16'b0, ea});
            end
            chk($sformatf("v%0d_idle", i), {31'b0, byte__valid}, 32'd0);
        end

        // 32 printable bytes across the address wrap, with a stall on byte 2
        clear_rx();
        stall_left = 3;
        send(16'hFFF0, {8{8'h61}}, {8{8'h61}}, {8{8'h61}}, {8{8'h61}});
        repeat (80) @(negedge clk);
        chk("stall_count", rx_d.size(), 32);
        chk("stall_used", stall_left, 0);
        for (int j = 0; j < 32 && j < rx_d.size(); j++) begin
            ea = 16'hFFF0 + j[15:0];
            chk($sformatf("wrap_byte%0d", j), {24'b0, rx_d[j]}, 32'h61);
            chk($sformatf("wrap_addr%0d", j), {16'b0, rx_a[j]}, {16'b0, ea});
        end
        chk("wrap_idle", {31'b0, byte__valid}, 32'd0);

        // asynchronous reset in the middle of an emission run
        clear_rx();
        send(16'h0300, {8{8'h62}}, {8{8'h62}}, {8{8'h62}}, {8{8'h62}});
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", {31'b0, byte__valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_ack", {31'b0, ack}, 32'd0);
        chk("mid_rst_valid", {31'b0, byte__valid}, 32'd0);
        chk("mid_rst_addr", {16'b0, byte__address}, 32'd0);
        chk("mid_rst_data", {24'b0, byte__data}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        clear_rx();
        repeat (40) @(negedge clk);
        chk("post_rst_no_bytes", rx_d.size(), 0);
        chk("post_rst_idle", {31'b0, byte__valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
